// File: rtl/i2s_tx_if.sv
// i2s_tx_if: frame input channel of the I2S transmitter.
// The mixer (master) offers a stereo frame with valid; the transmitter
// (slave) returns ready and its FIFO fill level.
interface i2s_tx_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         ldata;
    logic [WIDTH-1:0]         rdata;
    logic                     valid;
    logic                     ready;
    logic [$clog2(DEPTH):0]   level;

    modport master (output ldata, output rdata, output valid, input ready, input level);
    modport slave  (input ldata, input rdata, input valid, output ready, output level);
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: stereo serial audio transmitter (Philips I2S or left-justified)
// with a small frame FIFO, generating mck, sck and lr from the system clock.
// Build option: define I2S_HOLD_EN to repeat the last popped frame on
// underrun; without it an underrun frame is muted (all zeros).
// Serial data is produced by a 2*SLOT-bit frame image that is loaded at the
// frame boundary and shifted out MSB first, one bit per sck period.
module i2s_tx #(
    parameter int WIDTH   = 16,
    parameter int SLOT    = 32,
    parameter int SCK_DIV = 16,
    parameter int MCK_DIV = 4,
    parameter int DEPTH   = 4,
    parameter int MODE    = 0
) (
    input  logic    clock,
    input  logic    reset,
    i2s_tx_if.slave in_if,
    output logic    underrun,
    output logic    mck,
    output logic    sck,
    output logic    lr,
    output logic    d
);
    localparam int   SC_W    = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
    localparam int   MC_W    = (MCK_DIV > 2) ? $clog2(MCK_DIV) : 1;
    localparam int   FW      = 2 * SLOT;
    localparam int   BC_W    = $clog2(FW);
    localparam int   PW      = $clog2(DEPTH);
    localparam int   LW      = PW + 1;
    // Philips I2S delays the MSB by one bit after the lr transition.
    localparam int   OFF     = (MODE == 0) ? 1 : 0;
    localparam int   LSH     = SLOT - WIDTH - OFF;
    localparam logic LR_LEFT = (MODE == 0) ? 1'b0 : 1'b1;

    logic [SC_W-1:0]  sc_q, sc_d;
    logic [BC_W-1:0]  bc_q, bc_d;
    logic [MC_W-1:0]  mc_q, mc_d;
    logic             sck_q, sck_d;
    logic             mck_q, mck_d;
    logic             lr_q, lr_d;
    logic             sd_q, sd_d;
    logic [FW-1:0]    shift_q, shift_d;
    logic             underrun_q, underrun_d;
    logic             first_q, first_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] mem_l_q [DEPTH];
    logic [WIDTH-1:0] mem_r_q [DEPTH];
`ifdef I2S_HOLD_EN
    logic [WIDTH-1:0] last_l_q, last_l_d;
    logic [WIDTH-1:0] last_r_q, last_r_d;
`endif

    logic             sc_wrap;
    logic             boundary;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] load_l;
    logic [WIDTH-1:0] load_r;
    logic [SLOT-1:0]  img_l;
    logic [SLOT-1:0]  img_r;
    logic [FW-1:0]    img;

    // Counters, FIFO bookkeeping, frame loading and serial output next-state.
    always_comb begin
        sc_wrap    = (sc_q == SC_W'(SCK_DIV - 1));
        boundary   = sc_wrap && (bc_q == BC_W'(FW - 1));
        fifo_empty = (level_q == '0);
        push       = in_if.valid && ready_q;
        pop        = boundary && !fifo_empty;

        sc_d = sc_wrap ? '0 : sc_q + 1'b1;
        bc_d = bc_q;
        if (sc_wrap) begin
            bc_d = (bc_q == BC_W'(FW - 1)) ? '0 : bc_q + 1'b1;
        end
        mc_d  = (mc_q == MC_W'(MCK_DIV - 1)) ? '0 : mc_q + 1'b1;
        sck_d = (sc_d >= SC_W'(SCK_DIV / 2));
        mck_d = (mc_d >= MC_W'(MCK_DIV / 2));

        load_l = '0;
        load_r = '0;
        if (pop) begin
            load_l = mem_l_q[rd_ptr_q];
            load_r = mem_r_q[rd_ptr_q];
        end
`ifdef I2S_HOLD_EN
        else begin
            load_l = last_l_q;
            load_r = last_r_q;
        end
        last_l_d = last_l_q;
        last_r_d = last_r_q;
        if (pop) begin
            last_l_d = load_l;
            last_r_d = load_r;
        end
`endif
        img_l = SLOT'(load_l) << LSH;
        img_r = SLOT'(load_r) << LSH;
        img   = {img_l, img_r};

        // d and lr only move on the sck falling edge (sc wrapping to 0).
        shift_d = shift_q;
        sd_d    = sd_q;
        lr_d    = lr_q;
        if (sc_wrap) begin
            if (boundary) begin
                sd_d    = img[FW-1];
                shift_d = img << 1;
            end else begin
                sd_d    = shift_q[FW-1];
                shift_d = shift_q << 1;
            end
            lr_d = (bc_d < BC_W'(SLOT)) ? LR_LEFT : ~LR_LEFT;
        end

        // The boundary right after reset closes the silent start-up frame
        // and is not an underrun.
        underrun_d = boundary && fifo_empty && !first_q;
        first_d    = first_q && !boundary;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        ready_d  = (level_d < LW'(DEPTH));
    end

    // State registers with synchronous reset; reset flushes the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            sc_q       <= '0;
            bc_q       <= '0;
            mc_q       <= '0;
            sck_q      <= 1'b0;
            mck_q      <= 1'b0;
            lr_q       <= LR_LEFT;
            sd_q       <= 1'b0;
            shift_q    <= '0;
            underrun_q <= 1'b0;
            first_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
`ifdef I2S_HOLD_EN
            last_l_q   <= '0;
            last_r_q   <= '0;
`endif
        end else begin
            sc_q       <= sc_d;
            bc_q       <= bc_d;
            mc_q       <= mc_d;
            sck_q      <= sck_d;
            mck_q      <= mck_d;
            lr_q       <= lr_d;
            sd_q       <= sd_d;
            shift_q    <= shift_d;
            underrun_q <= underrun_d;
            first_q    <= first_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
`ifdef I2S_HOLD_EN
            last_l_q   <= last_l_d;
            last_r_q   <= last_r_d;
`endif
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_l_q[wr_ptr_q] <= in_if.ldata;
            mem_r_q[wr_ptr_q] <= in_if.rdata;
        end
    end

    assign in_if.ready = ready_q;
    assign in_if.level = level_q;
    assign underrun    = underrun_q;
    assign mck         = mck_q;
    assign sck         = sck_q;
    assign lr          = lr_q;
    assign d           = sd_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx. One Philips I2S instance (defaults)
// and one left-justified 24-bit instance share clock and reset. A bench-side
// cycle count since reset gives the expected sc/bc/mc timing.
module tb_i2s_tx;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    i2s_tx_if #(.WIDTH(16), .DEPTH(4)) if0 ();
    i2s_tx_if #(.WIDTH(24), .DEPTH(4)) if1 ();

    logic urun0, mck0, sck0, lr0, d0;
    logic urun1, mck1, sck1, lr1, d1;

    i2s_tx #(.WIDTH(16), .SLOT(32), .SCK_DIV(16), .MCK_DIV(4), .DEPTH(4), .MODE(0)) u0 (
        .clock(clock), .reset(reset), .in_if(if0),
        .underrun(urun0), .mck(mck0), .sck(sck0), .lr(lr0), .d(d0));

    i2s_tx #(.WIDTH(24), .SLOT(32), .SCK_DIV(16), .MCK_DIV(4), .DEPTH(4), .MODE(1)) u1 (
        .clock(clock), .reset(reset), .in_if(if1),
        .underrun(urun1), .mck(mck1), .sck(sck1), .lr(lr1), .d(d1));

    int cyc = 0;
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int   vectors = 0;
    int   miscompares = 0;
    logic dtrace [1024];

    function automatic logic [63:0] img16(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
    endfunction

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        @(negedge clock);
        while ((cyc % 1024) != p && n < 2100) begin
            @(negedge clock);
            n++;
        end
        if ((cyc % 1024) != p) begin
            miscompares++;
            $display("FAIL wait_pos timeout: pos %0d, wanted %0d", cyc % 1024, p);
        end
    endtask

    // Records one whole frame of d (pos 0..1023) from the chosen DUT, checking
    // the clocks, d stability within each bit, the recovered frame image and
    // the underrun pulses. Optionally pushes one frame at push_pos.
    task automatic capture(input int sel, input logic [63:0] exp_img, input int exp_urun,
                           input bit do_push, input int push_pos,
                           input logic [23:0] pl, input logic [23:0] pr, input string name);
        int n, bc, sc, clk_err, glitch, ucnt, upos;
        logic exp_lr, lr_v, sck_v, mck_v, u_v;
        logic [63:0] img;
        n = 0;
        while ((cyc % 1024) != 0 && n < 2100) begin
            @(negedge clock);
            n++;
        end
        if ((cyc % 1024) != 0) begin
            miscompares++;
            $display("FAIL %s align timeout: pos %0d, wanted 0", name, cyc % 1024);
        end
        clk_err = 0; ucnt = 0; upos = -1;
        for (int i = 0; i < 1024; i++) begin
            bc = i / 16;
            sc = i % 16;
            exp_lr = (sel == 0) ? (bc >= 32) : (bc < 32);
            dtrace[i] = (sel == 0) ? d0 : d1;
            lr_v  = (sel == 0) ? lr0 : lr1;
            sck_v = (sel == 0) ? sck0 : sck1;
            mck_v = (sel == 0) ? mck0 : mck1;
            u_v   = (sel == 0) ? urun0 : urun1;
            if (lr_v !== exp_lr || sck_v !== (sc >= 8) || mck_v !== ((cyc % 4) >= 2)) clk_err++;
            if (u_v === 1'b1) begin
                ucnt++;
                if (upos < 0) upos = i;
            end
            if (do_push && i == push_pos) begin
                if (sel == 0) begin
                    if0.ldata = pl[15:0]; if0.rdata = pr[15:0]; if0.valid = 1'b1;
                end else begin
                    if1.ldata = pl; if1.rdata = pr; if1.valid = 1'b1;
                end
            end
            if (do_push && i == push_pos + 1) begin
                if0.valid = 1'b0;
                if1.valid = 1'b0;
            end
            if (i != 1023) @(negedge clock);
        end
        glitch = 0;
        for (int i = 0; i < 1024; i++) begin
            if (dtrace[i] !== dtrace[(i / 16) * 16]) glitch++;
        end
        for (int b = 0; b < 64; b++) img[63 - b] = dtrace[b * 16 + 8];

        vectors++;
        if (img !== exp_img) begin
            miscompares++;
            $display("FAIL %s image: got %h, wanted %h", name, img, exp_img);
        end
        vectors++;
        if (glitch !== 0) begin
            miscompares++;
            $display("FAIL %s d_stable: %0d off-edge changes, wanted 0", name, glitch);
        end
        vectors++;
        if (clk_err !== 0) begin
            miscompares++;
            $display("FAIL %s clocks: %0d lr/sck/mck errors, wanted 0", name, clk_err);
        end
        vectors++;
        if (ucnt !== exp_urun || (exp_urun > 0 && upos !== 0)) begin
            miscompares++;
            $display("FAIL %s underrun: %0d pulses first at pos %0d, wanted %0d at pos 0",
                     name, ucnt, upos, exp_urun);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({mck0, sck0, d0, lr0, urun0} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_pins0: mck/sck/d/lr/urun = %b, wanted 00000",
                     {mck0, sck0, d0, lr0, urun0});
        end
        vectors++;
        if (if0.ready !== 1'b1 || if0.level !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_fifo0: ready %b level %0d, wanted ready 1 level 0",
                     if0.ready, if0.level);
        end
        vectors++;
        if ({mck1, sck1, d1, lr1, urun1, if1.ready} !== 6'b000101) begin
            miscompares++;
            $display("FAIL reset_pins1: mck/sck/d/lr/urun/ready = %b, wanted 000101",
                     {mck1, sck1, d1, lr1, urun1, if1.ready});
        end
        reset = 1'b0;
        capture(0, 64'h0, 0, 1'b0, 0, 24'h0, 24'h0, "first_frame");
    endtask

    task automatic test_single();
        capture(0, 64'h0, 0, 1'b1, 100, 24'h00A5A5, 24'h005A5A, "pre_single");
        vectors++;
        if (if0.level !== 3'd1) begin
            miscompares++;
            $display("FAIL single_level: level %0d, wanted 1", if0.level);
        end
        capture(0, 64'h52D28000_2D2D0000, 0, 1'b0, 0, 24'h0, 24'h0, "single");
        vectors++;
        if (dtrace[15] !== 1'b0 || dtrace[16] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_latency: d at pos15/16 = %b%b, wanted 01", dtrace[15], dtrace[16]);
        end
    endtask

    task automatic test_underrun();
`ifdef I2S_HOLD_EN
        capture(0, 64'h52D28000_2D2D0000, 1, 1'b0, 0, 24'h0, 24'h0, "underrun");
`else
        capture(0, 64'h0, 1, 1'b0, 0, 24'h0, 24'h0, "underrun");
`endif
        vectors++;
        if (if0.level !== 3'd0) begin
            miscompares++;
            $display("FAIL underrun_level: level %0d, wanted 0", if0.level);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bl [5];
        logic [15:0] br [5];
        bl = '{16'h8001, 16'hFFFF, 16'h1234, 16'h0001, 16'h7FFE};
        br = '{16'h0003, 16'h0000, 16'hFEDC, 16'h8000, 16'h5555};
        wait_pos(10);
        for (int k = 0; k < 5; k++) begin
            if0.ldata = bl[k];
            if0.rdata = br[k];
            if0.valid = 1'b1;
            @(negedge clock);
            if (k == 3) begin
                vectors++;
                if (if0.ready !== 1'b0 || if0.level !== 3'd4) begin
                    miscompares++;
                    $display("FAIL full_after_4: ready %b level %0d, wanted ready 0 level 4",
                             if0.ready, if0.level);
                end
            end
        end
        vectors++;
        if (if0.ready !== 1'b0 || if0.level !== 3'd4) begin
            miscompares++;
            $display("FAIL fifth_held: ready %b level %0d, wanted ready 0 level 4",
                     if0.ready, if0.level);
        end
        wait_pos(1023);
        vectors++;
        if (if0.ready !== 1'b0 || if0.level !== 3'd4) begin
            miscompares++;
            $display("FAIL pop_cycle: ready %b level %0d, wanted ready 0 level 4",
                     if0.ready, if0.level);
        end
        @(negedge clock);
        vectors++;
        if (if0.ready !== 1'b1 || if0.level !== 3'd3) begin
            miscompares++;
            $display("FAIL after_pop: ready %b level %0d, wanted ready 1 level 3",
                     if0.ready, if0.level);
        end
        @(negedge clock);
        if0.valid = 1'b0;
        vectors++;
        if (if0.ready !== 1'b0 || if0.level !== 3'd4) begin
            miscompares++;
            $display("FAIL fifth_accepted: ready %b level %0d, wanted ready 0 level 4",
                     if0.ready, if0.level);
        end
        for (int k = 1; k < 5; k++) begin
            capture(0, img16(bl[k], br[k]), 0, 1'b0, 0, 24'h0, 24'h0, $sformatf("b2b_frame%0d", k + 1));
        end
`ifdef I2S_HOLD_EN
        capture(0, img16(bl[4], br[4]), 1, 1'b0, 0, 24'h0, 24'h0, "drain");
`else
        capture(0, 64'h0, 1, 1'b0, 0, 24'h0, 24'h0, "drain");
`endif
    endtask

    task automatic test_left_just();
        capture(1, 64'h0, 1, 1'b1, 100, 24'h800001, 24'hC00003, "lj_pre");
        capture(1, 64'h80000100_C0000300, 0, 1'b0, 0, 24'h0, 24'h0, "left_just");
        vectors++;
        if (dtrace[0] !== 1'b1 || dtrace[23 * 16 + 8] !== 1'b1 || dtrace[24 * 16 + 8] !== 1'b0) begin
            miscompares++;
            $display("FAIL lj_bits: bc0/bc23/bc24 = %b%b%b, wanted 110",
                     dtrace[0], dtrace[23 * 16 + 8], dtrace[24 * 16 + 8]);
        end
    endtask

    task automatic test_reset_mid();
        wait_pos(100);
        if0.ldata = 16'hC3C3;
        if0.rdata = 16'h3C3C;
        if0.valid = 1'b1;
        @(negedge clock);
        if0.valid = 1'b0;
        vectors++;
        if (if0.level !== 3'd1) begin
            miscompares++;
            $display("FAIL mid_push: level %0d, wanted 1", if0.level);
        end
        wait_pos(320);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        vectors++;
        if (if0.level !== 3'd0 || if0.ready !== 1'b1 || {mck0, sck0, d0, lr0} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset: level %0d ready %b mck/sck/d/lr %b, wanted 0 1 0000",
                     if0.level, if0.ready, {mck0, sck0, d0, lr0});
        end
        capture(0, 64'h0, 0, 1'b0, 0, 24'h0, 24'h0, "mid_first");
        capture(0, 64'h0, 0, 1'b0, 0, 24'h0, 24'h0, "mid_boundary");
    endtask

    initial begin
        if0.valid = 1'b0; if0.ldata = '0; if0.rdata = '0;
        if1.valid = 1'b0; if1.ldata = '0; if1.rdata = '0;
        test_reset();
        test_single();
        test_underrun();
        test_back_to_back();
        test_left_just();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
